// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Runs the request-to-send sequence, clocks out one frame on device clock edges and checks the ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int SETUP_CYCLES   = 200,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX_A = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int CNT_MAX   = (TIMEOUT_CYCLES > CNT_MAX_A) ? TIMEOUT_CYCLES : CNT_MAX_A;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int FCW       = $clog2(FILTER_LEN + 1);

  localparam logic [CW-1:0]  INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0]  SET_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0]  TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [FCW-1:0] F_LAST   = FCW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  // Pad conditioning; index 0 is the clock line, index 1 the data line.
  logic [1:0]     w_pad;
  logic [1:0]     r_sync1;
  logic [1:0]     r_sync2;
  logic [1:0]     r_filt;
  logic [FCW-1:0] r_fcnt [2];
  logic           r_fall;

  assign w_pad = {ps2_data_in, ps2_clk_in};

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
      r_filt  <= 2'b11;
      r_fcnt  <= '{default: '0};
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= w_pad;
      r_sync2 <= r_sync1;
      r_fall  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == F_LAST) begin
          r_filt[i] <= r_sync2[i];
          r_fcnt[i] <= '0;
          if (i == 0) r_fall <= ~r_sync2[i];
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_data, w_data_nxt;
  logic          r_par, w_par_nxt;
  logic          r_nack, w_nack_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_error, w_error_nxt;
  logic          r_clk_oe, w_clk_oe_nxt;
  logic          r_data_oe, w_data_oe_nxt;
  logic          w_timeout;
  logic          w_abort;

  assign w_timeout = (r_cnt == TO_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_data_nxt    = r_data;
    w_par_nxt     = r_par;
    w_nack_nxt    = r_nack;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_error_nxt   = 1'b0;
    w_clk_oe_nxt  = r_clk_oe;
    w_data_oe_nxt = r_data_oe;
    w_abort       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (tx_start) begin
          w_state_nxt   = S_INHIBIT;
          w_cnt_nxt     = '0;
          w_data_nxt    = tx_data;
          w_par_nxt     = ~^tx_data;
          w_nack_nxt    = 1'b0;
          w_busy_nxt    = 1'b1;
          w_clk_oe_nxt  = 1'b1;
          w_data_oe_nxt = 1'b0;
        end
      end
      S_INHIBIT: begin
        if (r_cnt == INH_LAST) begin
          w_state_nxt   = S_REQ;
          w_cnt_nxt     = '0;
          w_data_oe_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_REQ: begin
        if (r_cnt == SET_LAST) begin
          w_state_nxt  = S_SHIFT;
          w_cnt_nxt    = '0;
          w_idx_nxt    = '0;
          w_clk_oe_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      // Each device clock fall moves the line to the next bit; the stop bit is a release.
      S_SHIFT: begin
        if (r_fall) begin
          w_cnt_nxt = '0;
          w_idx_nxt = r_idx + 1'b1;
          if (r_idx < 4'd8) begin
            w_data_oe_nxt = ~r_data[r_idx[2:0]];
          end else if (r_idx == 4'd8) begin
            w_data_oe_nxt = ~r_par;
          end else begin
            w_data_oe_nxt = 1'b0;
            w_state_nxt   = S_ACK;
          end
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_ACK: begin
        if (r_fall) begin
          w_cnt_nxt   = '0;
          w_nack_nxt  = r_filt[1];
          w_state_nxt = S_WAIT_IDLE;
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (r_filt == 2'b11) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_error_nxt = r_nack;
          w_cnt_nxt   = '0;
        end else if (r_fall) begin
          w_cnt_nxt = '0;
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_abort) begin
      w_state_nxt   = S_IDLE;
      w_cnt_nxt     = '0;
      w_busy_nxt    = 1'b0;
      w_done_nxt    = 1'b1;
      w_error_nxt   = 1'b1;
      w_clk_oe_nxt  = 1'b0;
      w_data_oe_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_data    <= '0;
      r_par     <= 1'b0;
      r_nack    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_data    <= w_data_nxt;
      r_par     <= w_par_nxt;
      r_nack    <= w_nack_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
      r_clk_oe  <= w_clk_oe_nxt;
      r_data_oe <= w_data_oe_nxt;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a behavioural PS/2 device
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int SET = 10;
  localparam int TO  = 600;
  localparam int FL  = 4;
  localparam int H   = 20;

  logic       clk_100mhz = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       busy, done, error, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_fall = 0;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (SET),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN    (FL)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk_100mhz = ~clk_100mhz;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    bit         nack;
    int         npulse;
    bit         exp_par;
    bit         exp_err;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_100mhz);
    #1;
  endtask

  // Odd parity from the frame rule: the parity bit makes the count of ones odd.
  function automatic bit model_parity(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (ones % 2) == 0;
  endfunction

  task automatic dev_pulse(output bit b);
    dev_clk = 1'b0;
    last_fall = cyc;
    repeat (H) step();
    dev_clk = 1'b1;
    repeat (H / 2) step();
    b = ps2_data_in;
    repeat (H / 2) step();
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input bit nack,
                           input int npulse, input bit exp_par, input bit exp_err,
                           input bit inject, input bit start_in_done);
    int  w, c, n_clk, first_data, nb, lim, done_cyc;
    bit  found;
    bit  bits [10];
    logic [7:0] got_byte;

    w = 0;
    while (busy && w < 2000) begin step(); w++; end
    check({tag, " idle_before_start"}, busy, 0);

    tx_data  = d;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    check({tag, " accept_busy"}, busy, 1);
    check({tag, " accept_clk_oe"}, ps2_clk_oe, 1);

    c = 1; n_clk = 0; first_data = 0;
    while (ps2_clk_oe && c < INH + SET + 50) begin
      n_clk++;
      if (ps2_data_oe && first_data == 0) first_data = c;
      if (inject && c == 5) begin
        tx_data  = 8'h55;
        tx_start = 1'b1;
      end else if (inject && c == 6) begin
        tx_start = 1'b0;
        tx_data  = ~d;
      end
      step();
      c++;
    end
    check({tag, " clk_low_cycles"}, n_clk, INH + SET);
    check({tag, " data_low_first_cycle"}, first_data, INH + 1);
    check({tag, " start_bit"}, ps2_data_in, 0);

    repeat (H) step();
    nb = (npulse < 10) ? npulse : 10;
    for (int k = 0; k < nb; k++) dev_pulse(bits[k]);

    if (npulse >= 11) begin
      dev_data = nack;
      repeat (4) step();
      dev_clk = 1'b0;
      last_fall = cyc;
      repeat (H) step();
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      lim = 200;
    end else begin
      lim = TO + 200;
    end

    found = 1'b0;
    for (int i = 0; i < lim && !found; i++) begin
      if (done) found = 1'b1;
      else step();
    end
    check({tag, " done_seen"}, found, 1);
    if (found) begin
      done_cyc = cyc;
      check({tag, " error_at_done"}, error, exp_err);
      check({tag, " busy_at_done"}, busy, 0);
      check({tag, " oe_at_done"}, {ps2_clk_oe, ps2_data_oe}, 0);
      if (npulse < 10) begin
        check({tag, " timeout_min"}, int'(done_cyc - last_fall >= TO), 1);
        check({tag, " timeout_max"}, int'(done_cyc - last_fall <= TO + 20), 1);
      end
      if (start_in_done) begin
        tx_data  = 8'h55;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        check({tag, " accept_in_done_busy"}, busy, 1);
        check({tag, " accept_in_done_clk_oe"}, ps2_clk_oe, 1);
      end else begin
        step();
        check({tag, " done_one_cycle"}, done, 0);
      end
    end

    if (npulse >= 10) begin
      for (int i = 0; i < 8; i++) got_byte[i] = bits[i];
      check({tag, " byte"}, got_byte, d);
      check({tag, " parity"}, bits[8], exp_par);
      check({tag, " stop"}, bits[9], 1);
    end
  endtask

  vec_t vecs [5];

  initial begin
    bit   b;
    int   w;
    vec_t v;

    vecs[0] = '{8'hED, 1'b0, 11, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 11, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 1'b0, 11, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 11, 1'b1, 1'b1};
    vecs[4] = '{8'hA5, 1'b0, 4,  1'b1, 1'b1};

    repeat (3) @(posedge clk_100mhz);
    #1;
    check("reset_busy", busy, 0);
    check("reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    rst = 1'b0;
    step();
    check("post_reset_done_error", {done, error}, 0);
    check("post_reset_busy", busy, 0);
    repeat (10) step();

    for (int i = 0; i < 5; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].nack, vecs[i].npulse,
                vecs[i].exp_par, vecs[i].exp_err, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      v.data    = 8'($urandom);
      v.nack    = 1'($urandom_range(0, 1));
      v.npulse  = 11;
      v.exp_par = model_parity(v.data);
      v.exp_err = v.nack;
      run_frame($sformatf("rnd%0d", i), v.data, v.nack, v.npulse, v.exp_par, v.exp_err,
                1'b0, 1'b0);
    end

    // Busy-ignored request during 0xF4, then a new request in the done cycle (0x55).
    run_frame("busy_ign", 8'hF4, 1'b0, 11, model_parity(8'hF4), 1'b0, 1'b1, 1'b1);

    w = 0;
    while (ps2_clk_oe && w < INH + SET + 50) begin step(); w++; end
    check("chain_clk_released", ps2_clk_oe, 0);
    repeat (H) step();
    dev_pulse(b);
    check("chain_bit0_presented", ps2_data_oe, 0);
    dev_clk = 1'b0;
    repeat (3) step();
    dev_clk = 1'b1;
    repeat (15) step();
    check("glitch_ignored", ps2_data_oe, 0);
    dev_pulse(b);
    check("bit1_after_glitch", ps2_data_oe, 1);
    check("busy_in_shift", busy, 1);

    @(posedge clk_100mhz);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("async_reset_busy", busy, 0);
    repeat (2) @(posedge clk_100mhz);
    #1;
    rst = 1'b0;
    step();
    check("after_reset_idle", {busy, done, error}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter, the send-side counterpart of the keyboard receiver. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the shared open-drain clock/data lines using the PS/2 request-to-send sequence. It monitors the device acknowledge and reports `done` or `error`. It sits beside the PS/2 receiver in the top level, and its open-drain enables are combined with the pad tristates there.

## Interface
- `INHIBIT_CYCLES`, default 12000: clock-low inhibit before request, 120 µs at 100 MHz.
- `SETUP_CYCLES`, default 200: data-low hold with clock still low before clock release, 2 µs.
- `TIMEOUT_CYCLES`, default 2000000: maximum wait between device clock falling edges, 20 ms.
- `FILTER_LEN`, default 8: consecutive equal samples required to change a filtered line level.
- `clk_100mhz`, in, 1: system clock. One clock domain only.
- `rst`, in, 1: reset, asynchronous, active-high.
- `tx_data`, in, 8: byte to send; sampled on accept.
- `tx_start`, in, 1: request; accepted only while `busy`=0.
- `busy`, out, 1: transfer in progress.
- `done`, out, 1: one-cycle pulse at end of every accepted transfer (success, NACK or timeout).
- `error`, out, 1: one-cycle pulse coincident with `done` on NACK or timeout.
- `ps2_clk_in`, in, 1: raw PS/2 clock pad level (asynchronous).
- `ps2_data_in`, in, 1: raw PS/2 data pad level (asynchronous).
- `ps2_clk_oe`, out, 1: 1 = drive clock pad low; 0 = release.
- `ps2_data_oe`, out, 1: 1 = drive data pad low; 0 = release.

## Operation
- Input conditioning: both pad inputs pass through a 2-FF synchronizer, then a `FILTER_LEN` filter.
  - Filtered level changes only after `FILTER_LEN` consecutive equal synchronized samples.
  - Filter outputs reset to 1.
  - `fall` = filtered clock 1→0, one cycle.
- Frame: 11 bits. Start bit (0), d0..d7 LSB first, odd parity (`~^tx_data`), stop bit (1). The device then returns an ACK bit.
- States:
  - IDLE: `busy`=0, both oe=0. On `tx_start`, latch `tx_data` and the computed parity, then go to INHIBIT.
  - INHIBIT: `ps2_clk_oe`=1 for exactly `INHIBIT_CYCLES` cycles, then go to REQ.
  - REQ: `ps2_clk_oe`=1 and `ps2_data_oe`=1 (start bit) for `SETUP_CYCLES` cycles, then go to SHIFT with bit index 0.
  - SHIFT: `ps2_clk_oe`=0. `ps2_data_oe` holds its value except on `fall`.
    - On `fall` with index 0..7: present `d[index]`, i.e. `ps2_data_oe` = ~bit.
    - On `fall` with index 8: present parity.
    - On `fall` with index 9: release data (stop bit) and go to ACK.
    - Index increments on each `fall`.
  - ACK: on `fall`, sample filtered data. 0 → ACK ok; 1 → NACK, with the error flag set. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until filtered clock=1 and filtered data=1, then go to IDLE, pulsing `done` (and `error` if flagged).
- Timeout: a counter runs in SHIFT, ACK and WAIT_IDLE. It clears on entry to SHIFT and on every `fall`. When it reaches `TIMEOUT_CYCLES`, release both lines immediately and go to IDLE with `done`=1 and `error`=1.
- `tx_start` while `busy`=1 is ignored; there is no queue.
- `tx_data` changes after accept do not affect the frame in flight.
- Device clock edges seen in IDLE, INHIBIT or REQ are ignored.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `done`, `error`, `ps2_clk_oe` and `ps2_data_oe` all 0.
  - Counters 0; filters 1.
  - Reset mid-transfer releases both lines asynchronously.
- Accept: `tx_start` high in cycle N (IDLE) gives `busy`=1 and `ps2_clk_oe`=1 from cycle N+1.
- `ps2_clk_oe` is high for exactly `INHIBIT_CYCLES`+`SETUP_CYCLES` cycles.
- `ps2_data_oe` rises on the first REQ cycle.
- Edge latency: pad clock fall → `fall` takes 2 (sync) + `FILTER_LEN` cycles. `ps2_data_oe` updates the cycle after `fall`.
- `done`/`error` are registered and high in the first IDLE cycle, with `busy`=0 in that same cycle.
- A `tx_start` in the `done` cycle is accepted.
- All outputs are registered. No combinational pad-to-output path.

## Test plan
- Send 0xED with a behavioral device model (clock period 80 µs, ACK=0):
  - clock held low exactly 12200 cycles, data low from cycle 12001;
  - device captures bits 1,0,1,1,0,1,1,1 LSB first, parity 1, stop 1;
  - `done`=1, `error`=0 once lines are idle.
- Send 0x00: parity bit = 1. Send 0x01: parity bit = 0. Model checks parity and stop bit on each frame.
- Model drives ACK=1 (NACK) on 0xFF: `done`=1 and `error`=1 in the same cycle, both lines released.
- Model stops clocking after 4 bits: after 2000000 cycles without `fall`, `done`=`error`=1 and both oe=0.
- Pulse `tx_start` with 0x55 during a busy transfer of 0xF4: only 0xF4 is sent. Then assert `tx_start` in the `done` cycle: it is accepted and `busy`=1 next cycle.
- Assert `rst` during SHIFT: both oe=0 immediately, `busy`=0. Inject 3-cycle glitches on the clock pad: no `fall`, bit index unchanged.
